// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results into one register-file write port.
// Optional WB_BYPASS_EN lets a load skip the empty FIFO when the ALU is idle.
module writeback_arbiter #(
    parameter int unsigned LEN_REG    = 32,
    parameter int unsigned LEN_REGNO  = 4,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [LEN_REGNO-1:0] alu_r_i,
    input  logic [LEN_REG-1:0]   alu_data_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [LEN_REGNO-1:0] mem_r_i,
    input  logic [LEN_REG-1:0]   mem_data_i,
    output logic                 wb_o,
    output logic [LEN_REGNO-1:0] wb_r_o,
    output logic [LEN_REG-1:0]   result_o,
    output logic [NUM_REGS-1:0]  release_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ALU_FIRST = 1'b0,
        MEM_FIRST = 1'b1
    } mode_e;

    logic [LEN_REGNO-1:0] fifo_r_q    [FIFO_DEPTH];
    logic [LEN_REGNO-1:0] fifo_r_d    [FIFO_DEPTH];
    logic [LEN_REG-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [LEN_REG-1:0]   fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 wb_q, wb_d;
    logic [LEN_REGNO-1:0] wb_r_q, wb_r_d;
    logic [LEN_REG-1:0]   result_q, result_d;
    logic [NUM_REGS-1:0]  release_q, release_d;

    mode_e mode_c;
    logic  alu_win_c;
    logic  pop_c;
    logic  push_c;
    logic  bypass_c;

    // Mode depends only on the registered count, so both readies are glitch-free decodes.
    always_comb begin
        mode_c = (count_q >= CNT_W'(FIFO_DEPTH - 1)) ? MEM_FIRST : ALU_FIRST;
    end

    assign alu_ready_o = (mode_c == ALU_FIRST);
    assign mem_ready_o = (count_q != CNT_W'(FIFO_DEPTH));

`ifdef WB_BYPASS_EN
    assign bypass_c = (count_q == '0) && !alu_valid_i && mem_valid_i;
`else
    assign bypass_c = 1'b0;
`endif

    assign alu_win_c = alu_valid_i && (mode_c == ALU_FIRST);
    assign pop_c     = (count_q != '0) && ((mode_c == MEM_FIRST) || !alu_valid_i);
    assign push_c    = mem_valid_i && mem_ready_o && !bypass_c;

    // FIFO next state: tail write, head advance, occupancy.
    always_comb begin
        fifo_r_d    = fifo_r_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_c) begin
            fifo_r_d[wr_ptr_q]    = mem_r_i;
            fifo_data_d[wr_ptr_q] = mem_data_i;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output register selection; data and register number hold when idle.
    always_comb begin
        wb_d      = 1'b0;
        wb_r_d    = wb_r_q;
        result_d  = result_q;
        release_d = '0;
        if (alu_win_c) begin
            wb_d     = 1'b1;
            wb_r_d   = alu_r_i;
            result_d = alu_data_i;
        end else if (pop_c) begin
            wb_d     = 1'b1;
            wb_r_d   = fifo_r_q[rd_ptr_q];
            result_d = fifo_data_q[rd_ptr_q];
        end else if (bypass_c) begin
            wb_d     = 1'b1;
            wb_r_d   = mem_r_i;
            result_d = mem_data_i;
        end
        if (wb_d) begin
            release_d = NUM_REGS'(1) << wb_r_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_r_q[i]    <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_q      <= 1'b0;
            wb_r_q    <= '0;
            result_q  <= '0;
            release_q <= '0;
        end else begin
            fifo_r_q    <= fifo_r_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wb_q        <= wb_d;
            wb_r_q      <= wb_r_d;
            result_q    <= result_d;
            release_q   <= release_d;
        end
    end

    assign wb_o      = wb_q;
    assign wb_r_o    = wb_r_q;
    assign result_o  = result_q;
    assign release_o = release_q;

endmodule
